// File: rtl/wshb_mire_pkg.sv
// mire_pkg: shared types and constants for the Wishbone test-pattern master.
//   state_t   : FSM state encoding (IDLE / WRITE / PAUSE)
//   WHITE     : RGB565 white pixel value
//   BLACK     : RGB565 black pixel value
//   GRID_LOG2 : log2 of the grid pitch in pixels (16-pixel grid)
package mire_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [15:0] WHITE     = 16'hFFFF;
  localparam logic [15:0] BLACK     = 16'h0000;
  localparam int          GRID_LOG2 = 4;

endpackage

// File: rtl/wshb_mire_if.sv
// wshb_mire_if: Wishbone classic write bus between the pattern master and
// the framebuffer slave.
//   master modport: drives adr/dat_ms/we/sel/cti/bte/stb/cyc, samples ack
//   slave  modport: samples the request, drives ack
// Handshake: stb is the valid, ack is the ready. A beat transfers on the
// rising clock edge where stb && ack; while stb && !ack the master holds
// adr and dat_ms unchanged. cyc frames the bus tenure and is high whenever
// stb is high.
interface wshb_mire_if;
  logic [31:0] adr;
  logic [15:0] dat_ms;
  logic        we;
  logic [1:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        stb;
  logic        cyc;
  logic        ack;

  modport master (
    output adr, dat_ms, we, sel, cti, bte, stb, cyc,
    input  ack
  );

  modport slave (
    input  adr, dat_ms, we, sel, cti, bte, stb, cyc,
    output ack
  );
endinterface

// File: rtl/wshb_mire_pixel.sv
// mire_pixel: combinational pattern generator for the test grid.
//   x      in  GRID_LOG2 : low bits of the pixel column
//   y      in  GRID_LOG2 : low bits of the pixel row
//   rgb565 out 16        : WHITE on a grid line, BLACK elsewhere
// Only the bits below the grid pitch matter, so the caller passes just those.
module mire_pixel
  import mire_pkg::*;
(
  input  logic [GRID_LOG2-1:0] x,
  input  logic [GRID_LOG2-1:0] y,
  output logic [15:0]          rgb565
);

  logic w_on_grid;

  assign w_on_grid = (x == '0) || (y == '0);
  assign rgb565    = w_on_grid ? WHITE : BLACK;

endmodule

// File: rtl/wshb_mire.sv
// wshb_mire: Wishbone classic write master that fills a framebuffer with a
// 16-pixel white grid on black, one pixel per accepted write, in bursts of
// BURST writes separated by a one-cycle bus release.
//   clk         in  : bus clock
//   rst         in  : asynchronous active-high reset
//   enable      in  : 1 = keep generating, 0 = stop after the pending write
//   wb          master modport of wshb_mire_if (see handshake there)
//   frame_done  out : one-cycle pulse after the last pixel of a frame is accepted
//   o_dbg_state out : current FSM state
module wshb_mire
  import mire_pkg::*;
#(
  parameter int HDISP = 640,
  parameter int VDISP = 480,
  parameter int BURST = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  wshb_mire_if.master      wb,
  output logic             frame_done,
  output state_t           o_dbg_state
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BW = $clog2(BURST + 1);

  localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BURST - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [BW-1:0] r_bcnt;
  logic          r_frame_done;

  logic          w_stb;
  logic          w_acc;
  logic          w_x_last;
  logic          w_y_last;
  logic          w_burst_end;
  logic [31:0]   w_pix_idx;
  logic [15:0]   w_rgb;

  assign w_acc       = w_stb && wb.ack;
  assign w_x_last    = (r_x == X_LAST);
  assign w_y_last    = (r_y == Y_LAST);
  assign w_burst_end = (r_bcnt == B_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic. A burst end wins over a falling enable: PAUSE then
  // decides between WRITE and IDLE on the following cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (enable) w_next_state = ST_WRITE;
      end
      ST_WRITE: begin
        if (w_acc) begin
          if (w_burst_end)  w_next_state = ST_PAUSE;
          else if (!enable) w_next_state = ST_IDLE;
        end
      end
      ST_PAUSE: begin
        w_next_state = enable ? ST_WRITE : ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register only, so reset drops stb/cyc
  // without waiting for a clock edge.
  always_comb begin
    w_stb       = (r_state == ST_WRITE);
    o_dbg_state = r_state;
  end

  // Pixel position and burst counter advance only on accepted writes and are
  // left untouched in IDLE so a resume continues where it stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x          <= '0;
      r_y          <= '0;
      r_bcnt       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_acc && w_x_last && w_y_last;
      if (w_acc) begin
        if (w_x_last) begin
          r_x <= '0;
          r_y <= w_y_last ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
        r_bcnt <= w_burst_end ? '0 : r_bcnt + 1'b1;
      end
    end
  end

  // Pixel index widened to 32 bits before the multiply so no product bits
  // are lost; byte address is twice the index (16-bit pixels).
  assign w_pix_idx = 32'(r_y) * 32'(HDISP) + 32'(r_x);

  mire_pixel u_pixel (
    .x      (r_x[GRID_LOG2-1:0]),
    .y      (r_y[GRID_LOG2-1:0]),
    .rgb565 (w_rgb)
  );

  assign wb.adr     = w_pix_idx << 1;
  assign wb.dat_ms  = w_rgb;
  assign wb.we      = 1'b1;
  assign wb.sel     = 2'b11;
  assign wb.cti     = 3'b000;
  assign wb.bte     = 2'b00;
  assign wb.stb     = w_stb;
  assign wb.cyc     = w_stb;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_wshb_mire.sv
module tb_wshb_mire;
  import mire_pkg::*;

  // Instance B: small frame, randomized slave, checked every cycle.
  localparam int BH = 32;
  localparam int BV = 4;
  localparam int BB = 64;
  localparam int BN = BH * BV;
  // Instance A: default geometry, zero-wait slave, memory image checked.
  localparam int AH = 640;
  localparam int AV = 480;
  localparam int AB = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   a_rst = 1'b1, b_rst = 1'b1;
  logic   a_en  = 1'b0, b_en  = 1'b0;
  logic   a_fd, b_fd;
  state_t a_st, b_st;

  wshb_mire_if a_bus ();
  wshb_mire_if b_bus ();

  wshb_mire #(.HDISP(AH), .VDISP(AV), .BURST(AB)) dut_a (
    .clk(clk), .rst(a_rst), .enable(a_en), .wb(a_bus),
    .frame_done(a_fd), .o_dbg_state(a_st)
  );

  wshb_mire #(.HDISP(BH), .VDISP(BV), .BURST(BB)) dut_b (
    .clk(clk), .rst(b_rst), .enable(b_en), .wb(b_bus),
    .frame_done(b_fd), .o_dbg_state(b_st)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] pattern(input int x, input int y);
    return ((x % 16) == 0 || (y % 16) == 0) ? 16'hFFFF : 16'h0000;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_b_stb(input string nm);
    int k = 0;
    while (!b_bus.stb && k < 200) begin
      step(1);
      k++;
    end
    if (!b_bus.stb) check(nm, 0, 1);
  endtask

  // ---------------- instance B: model + scoreboard ----------------
  // Model view: pixels are written in raster order (index m_idx); the bus
  // is busy until a write is acked; after every BB acks in a tenure the bus
  // goes quiet for one cycle; when quiet it becomes busy iff enable is high.
  logic [31:0] exp_q[$];
  int          m_idx = 0, m_cnt = 0, m_fd_count = 0, b_fd_count = 0;
  bit          m_cyc = 0, m_fd = 0;
  bit          stall = 0;
  int          wlo = 0, whi = 0, wcnt = 0, wtarget = 0;
  logic [31:0] last_acc_adr = '0;

  always @(negedge clk) begin : b_compare
    bit          acc;
    logic [31:0] e;
    if (b_rst) begin
      m_idx = 0; m_cnt = 0; m_cyc = 0; m_fd = 0; wcnt = 0;
      exp_q.delete();
      for (int i = 0; i < BN * 40; i++) exp_q.push_back(32'(2 * (i % BN)));
      b_bus.ack = 1'b1;  // a late ack held across reset must be ignored
      check("b_rst_stb", b_bus.stb, 0);
      check("b_rst_cyc", b_bus.cyc, 0);
      check("b_rst_fd",  b_fd, 0);
    end else begin
      check("b_cyc", b_bus.cyc, m_cyc);
      check("b_stb", b_bus.stb, m_cyc);
      check("b_fd",  b_fd, m_fd);
      if (m_cyc) begin
        check("b_adr", b_bus.adr, 32'(2 * m_idx));
        check("b_dat", b_bus.dat_ms, pattern(m_idx % BH, m_idx / BH));
        check("b_const", {b_bus.we, b_bus.sel, b_bus.cti, b_bus.bte}, 8'b1110_0000);
      end
      if (b_fd) begin
        b_fd_count++;
        check("b_fd_adr", last_acc_adr, 254);
      end
      // slave: ack after wtarget wait cycles unless stalled
      if (b_bus.stb && !stall) begin
        if (wcnt >= wtarget) begin
          b_bus.ack = 1'b1;
          wcnt      = 0;
          wtarget   = $urandom_range(whi, wlo);
        end else begin
          b_bus.ack = 1'b0;
          wcnt++;
        end
      end else begin
        b_bus.ack = 1'b0;
      end
      // scoreboard of accepted writes, in order
      if (b_bus.stb && b_bus.ack) begin
        if (exp_q.size() == 0) check("b_sb_empty", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("b_sb_adr", b_bus.adr, e);
          check("b_sb_dat", b_bus.dat_ms, pattern(int'(e / 2) % BH, int'(e / 2) / BH));
        end
        last_acc_adr = b_bus.adr;
      end
      // advance the model to the next cycle
      acc  = m_cyc && b_bus.ack;
      m_fd = acc && (m_idx == BN - 1);
      if (m_fd) m_fd_count++;
      if (m_cyc) begin
        if (acc) begin
          m_idx = (m_idx + 1) % BN;
          m_cnt++;
          if (m_cnt == BB) begin
            m_cnt = 0;
            m_cyc = 0;
          end else begin
            m_cyc = b_en;
          end
        end
      end else begin
        m_cyc = b_en;
      end
    end
  end

  // ---------------- instance A: zero-wait slave + memory ----------------
  logic [15:0] a_mem[int];
  int          a_acks = 0, a_ncyc = 0;
  int          a_c1 = 0, a_c64 = 0, a_c65 = 0;
  logic [31:0] a_adr1 = '1, a_adr2 = '1;
  logic [15:0] a_dat1 = '0, a_dat2 = '1;

  always @(negedge clk) begin : a_slave
    a_ncyc++;
    if (a_rst) begin
      a_bus.ack = 1'b0;
    end else begin
      a_bus.ack = a_bus.stb;
      if (a_bus.stb) begin
        a_mem[int'(a_bus.adr)] = a_bus.dat_ms;
        a_acks++;
        if (a_acks == 1)  begin a_c1 = a_ncyc; a_adr1 = a_bus.adr; a_dat1 = a_bus.dat_ms; end
        if (a_acks == 2)  begin a_adr2 = a_bus.adr; a_dat2 = a_bus.dat_ms; end
        if (a_acks == 64) a_c64 = a_ncyc;
        if (a_acks == 65) a_c65 = a_ncyc;
      end
    end
  end

  function automatic logic [31:0] a_pix(input int x, input int y);
    int k = 2 * (y * AH + x);
    return a_mem.exists(k) ? {16'h0, a_mem[k]} : 32'hDEAD_BEEF;
  endfunction

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] a0;
    int          k;

    step(3);
    check("b_rst_adr",   b_bus.adr, 0);
    check("b_rst_dat",   b_bus.dat_ms, 16'hFFFF);
    check("b_rst_state", b_st, ST_IDLE);
    check("a_rst_adr",   a_bus.adr, 0);
    check("a_rst_dat",   a_bus.dat_ms, 16'hFFFF);
    a_rst = 1'b0;
    b_rst = 1'b0;
    step(2);
    a_en = 1'b1;
    b_en = 1'b1;

    // zero-wait full frame on B
    step(140);
    check("b_first_frame_fd", b_fd_count, 1);
    step(160);

    // three wait states per pixel
    wlo = 3; whi = 3;
    step(200);

    // enable drops while the ack is stalled
    wlo = 0; whi = 0;
    wait_b_stb("b_drop_wait");
    stall = 1'b1;
    b_en  = 1'b0;
    a0    = b_bus.adr;
    step(3);
    check("b_drop_hold_stb", b_bus.stb, 1);
    check("b_drop_hold_adr", b_bus.adr, a0);
    stall = 1'b0;
    step(8);
    check("b_drop_idle_cyc",   b_bus.cyc, 0);
    check("b_drop_idle_state", b_st, ST_IDLE);
    step(5);
    check("b_drop_stay_cyc", b_bus.cyc, 0);
    b_en = 1'b1;
    wait_b_stb("b_resume_wait");
    check("b_resume_adr", b_bus.adr, (a0 + 2) % (2 * BN));

    // randomized wait states and enable toggling
    for (int s = 0; s < 75; s++) begin
      whi  = $urandom_range(3, 0);
      b_en = ($urandom_range(9, 0) != 0);
      step(20);
    end
    b_en = 1'b1;

    // reset in the middle of a transfer
    wait_b_stb("b_rst_mid_wait");
    #1;
    b_rst = 1'b1;
    #1;
    check("b_rst_async_stb",   b_bus.stb, 0);
    check("b_rst_async_cyc",   b_bus.cyc, 0);
    check("b_rst_async_state", b_st, ST_IDLE);
    step(2);
    b_rst = 1'b0;
    wait_b_stb("b_restart_wait");
    check("b_restart_adr", b_bus.adr, 0);
    check("b_restart_dat", b_bus.dat_ms, 16'hFFFF);
    step(100);
    b_en = 1'b0;
    step(10);
    check("b_end_cyc", b_bus.cyc, 0);
    check("b_fd_total", b_fd_count, m_fd_count);

    // let A reach row 32 of the default frame
    k = 0;
    while (a_acks < 32 * AH + 10 && k < 30000) begin
      step(1);
      k++;
    end
    check("a_progress", (a_acks >= 32 * AH + 10), 1);
    a_en = 1'b0;
    step(5);
    check("a_end_cyc",  a_bus.cyc, 0);
    check("a_adr1",     a_adr1, 0);
    check("a_dat1",     a_dat1, 16'hFFFF);
    check("a_adr2",     a_adr2, 2);
    check("a_dat2",     a_dat2, 16'hFFFF);
    check("a_burst_span", a_c64 - a_c1, 63);
    check("a_pause_gap",  a_c65 - a_c64, 2);
    check("a_px_17_5",  a_pix(17, 5), 16'h0000);
    check("a_px_16_5",  a_pix(16, 5), 16'hFFFF);
    check("a_px_3_32",  a_pix(3, 32), 16'hFFFF);
    check("a_px_1_1",   a_pix(1, 1),  16'h0000);
    check("a_px_5_0",   a_pix(5, 0),  16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
